unpadder: RTL and testbench



---
 rtl/sha3_pkg.sv | 29 ++
 rtl/unpad_byte_scan.sv | 56 +++++
 rtl/unpadder.sv | 154 +++++++++++++++
 tb/tb_unpadder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha3_pkg.sv
// Shared SHA-3 block constants and the unpadder state encoding.
// Imported by the unpadder and its byte scanner.
package sha3_pkg;

  localparam int RATE_WORDS = 18;
  localparam logic [7:0] PAD_FIRST = 8'h06;
  localparam logic [7:0] PAD_LAST = 8'h80;
  localparam logic [4:0] LAST_IDX = 5'(RATE_WORDS - 1);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  // Keep the first n message bytes of a word, MSB first.
  function automatic logic [31:0] keep_mask(input logic [1:0] n);
    logic [31:0] m;
    case (n)
      2'd0: m = 32'h0000_0000;
      2'd1: m = 32'hFF00_0000;
      2'd2: m = 32'hFFFF_0000;
      default: m = 32'hFFFF_FF00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/unpad_byte_scan.sv
// Finds the pad start byte in one buffered word, searching from the
// last byte of the word towards the first.
module unpad_byte_scan
  import sha3_pkg::*;
(
  input  logic [31:0] word,
  input  logic        is_word17,
  output logic        found,
  output logic [1:0]  pos,
  output logic        bad
);

  logic       hit;
  logic [1:0] k;
  logic [7:0] v;

  // In word 17 the low byte holds the closing pad, so it is skipped.
  always_comb begin
    hit = 1'b0;
    k = 2'd0;
    v = 8'h00;
    if (!is_word17 && word[7:0] != 8'h00) begin
      hit = 1'b1;
      k = 2'd3;
      v = word[7:0];
    end else if (word[15:8] != 8'h00) begin
      hit = 1'b1;
      k = 2'd2;
      v = word[15:8];
    end else if (word[23:16] != 8'h00) begin
      hit = 1'b1;
      k = 2'd1;
      v = word[23:16];
    end else if (word[31:24] != 8'h00) begin
      hit = 1'b1;
      k = 2'd0;
      v = word[31:24];
    end
  end

  always_comb begin
    found = 1'b0;
    bad = 1'b0;
    pos = k;
    if (is_word17 && word[7:0] == (PAD_FIRST | PAD_LAST)) begin
      found = 1'b1;
      pos = 2'd3;
    end else if (is_word17 && word[7:0] != PAD_LAST) begin
      bad = 1'b1;
    end else if (hit) begin
      found = (v == PAD_FIRST);
      bad = (v != PAD_FIRST);
    end
  end

endmodule

// File: rtl/unpadder.sv
// SHA-3 pad10*1 remover: buffers one rate block, locates the pad on
// final blocks and replays the message words with last/byte_num.
module unpadder
  import sha3_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [1:0]  out_byte_num,
  output logic        out_err
);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  last_q, last_d;
  logic [1:0]  bn_q, bn_d;
  logic        fin_q, fin_d;
  logic [31:0] blk_q [RATE_WORDS];

  logic        take;
  logic [31:0] cur;
  logic        found, bad;
  logic [1:0]  pos;

  assign take = in_valid & in_ready;
  assign cur = blk_q[cnt_q];

  unpad_byte_scan u_scan (
    .word      (cur),
    .is_word17 (cnt_q == LAST_IDX),
    .found     (found),
    .pos       (pos),
    .bad       (bad)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FILL;
    else state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 5'd0;
      last_q <= 5'd0;
      bn_q <= 2'd0;
      fin_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      last_q <= last_d;
      bn_q <= bn_d;
      fin_q <= fin_d;
    end
  end

  always_ff @(posedge clk) begin
    if (take) blk_q[cnt_q] <= in;
  end

  // cnt doubles as fill index, scan word index and drain index.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    last_d = last_q;
    bn_d = bn_q;
    fin_d = fin_q;
    unique case (state_q)
      ST_FILL: begin
        if (take) begin
          if (in_last && cnt_q != LAST_IDX) begin
            state_d = ST_ERR;
            cnt_d = 5'd0;
          end else if (cnt_q == LAST_IDX) begin
            if (in_last) begin
              state_d = ST_SCAN;
            end else begin
              state_d = ST_DRAIN;
              cnt_d = 5'd0;
              last_d = LAST_IDX;
              bn_d = 2'd0;
              fin_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      ST_SCAN: begin
        if (bad) begin
          state_d = ST_ERR;
          cnt_d = 5'd0;
        end else if (found) begin
          state_d = ST_DRAIN;
          cnt_d = 5'd0;
          last_d = cnt_q;
          bn_d = pos;
          fin_d = 1'b1;
        end else if (cnt_q == 5'd0) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (cnt_q == last_q) begin
            state_d = ST_FILL;
            cnt_d = 5'd0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      ST_ERR: begin
        state_d = ST_FILL;
        cnt_d = 5'd0;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    out_valid = 1'b0;
    out = 32'h0;
    out_last = 1'b0;
    out_byte_num = 2'd0;
    out_err = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ST_FILL: in_ready = 1'b1;
        ST_DRAIN: begin
          out_valid = 1'b1;
          if (fin_q && cnt_q == last_q) begin
            out_last = 1'b1;
            out_byte_num = bn_q;
            out = cur & keep_mask(bn_q);
          end else begin
            out = cur;
          end
        end
        ST_ERR: out_err = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unpadder.sv
// Directed bench for the SHA-3 unpadder: hand-built padded blocks
// with hand-computed message words, backpressure and error cases.
module tb_unpadder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [1:0]  out_byte_num;
  logic        out_err;

  int total = 0;
  int passed = 0;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic [1:0]  n;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] blk [18];

  unpadder dut (
    .clk          (clk),
    .reset        (reset),
    .in           (in),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .out          (out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .out_byte_num (out_byte_num),
    .out_err      (out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic push(input logic [31:0] d, input logic l,
                      input logic [1:0] n);
    exp_q.push_back({d, l, n});
  endtask

  task automatic clear_blk();
    for (int i = 0; i < 18; i++) blk[i] = 32'h0;
  endtask

  task automatic send_blk(input bit fin);
    for (int i = 0; i < 18; i++) begin
      in = blk[i];
      in_valid = 1'b1;
      in_last = fin && (i == 17);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    in = 32'h0;
  endtask

  task automatic drain(input string tag, input bit bp);
    int cyc = 0;
    int ph = 0;
    bit stall = 0;
    bit err_seen = 0;
    logic [34:0] prev = '0;
    beat_t g;
    while (exp_q.size() != 0 && cyc < 400) begin
      out_ready = bp ? (ph % 2 == 0) : 1'b1;
      ph++;
      if (out_err) err_seen = 1;
      if (out_valid) begin
        chk({tag, " in_ready_busy"}, in_ready, 0);
        if (stall)
          chk({tag, " stable"}, {out, out_last, out_byte_num}, prev);
        if (out_ready) begin
          g = exp_q.pop_front();
          chk({tag, " word"}, {out, out_last, out_byte_num}, g);
          stall = 0;
        end else begin
          stall = 1;
          prev = {out, out_last, out_byte_num};
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk({tag, " left"}, exp_q.size(), 0);
    exp_q.delete();
    out_ready = 1'b1;
    chk({tag, " no_err"}, err_seen, 0);
    chk({tag, " idle_valid"}, out_valid, 0);
    chk({tag, " idle_ready"}, in_ready, 1);
  endtask

  task automatic expect_err(input string tag);
    int errs = 0;
    int vals = 0;
    bit after = 0;
    for (int c = 0; c < 30; c++) begin
      if (after) begin
        chk({tag, " ready_after_err"}, in_ready, 1);
        after = 0;
      end
      if (out_valid) vals++;
      if (out_err) begin
        errs++;
        after = 1;
      end
      @(negedge clk);
    end
    chk({tag, " err_pulses"}, errs, 1);
    chk({tag, " no_valid"}, vals, 0);
  endtask

  task automatic small_blk(input string tag);
    clear_blk();
    blk[0] = 32'h11223306;
    blk[17] = 32'h00000080;
    push(32'h11223300, 1'b1, 2'd3);
    send_blk(1);
    drain(tag, 0);
  endtask

  initial begin
    in = 32'h0;
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst in_ready", in_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_last", out_last, 0);
    chk("rst byte_num", out_byte_num, 0);
    chk("rst out", out, 0);
    chk("rst out_err", out_err, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst in_ready", in_ready, 1);

    // empty message
    clear_blk();
    blk[0] = 32'h06000000;
    blk[17] = 32'h00000080;
    push(32'h0, 1'b1, 2'd0);
    send_blk(1);
    drain("empty", 0);

    small_blk("len3");

    // 71 bytes with 1010 backpressure on the drain
    clear_blk();
    for (int i = 0; i < 17; i++) begin
      blk[i] = {8'(i + 1), 24'hC0FFEE};
      push({8'(i + 1), 24'hC0FFEE}, 1'b0, 2'd0);
    end
    blk[17] = 32'hAABBCC86;
    push(32'hAABBCC00, 1'b1, 2'd3);
    send_blk(1);
    drain("len71_bp", 1);

    // 70 bytes: pad start in the middle of word 17
    clear_blk();
    for (int i = 0; i < 17; i++) begin
      blk[i] = 32'h5A000000 + i;
      push(32'h5A000000 + i, 1'b0, 2'd0);
    end
    blk[17] = 32'hAABB0680;
    push(32'hAABB0000, 1'b1, 2'd2);
    send_blk(1);
    drain("len70", 0);

    // 4 bytes: empty trailing word
    clear_blk();
    blk[0] = 32'hDEADBEEF;
    blk[1] = 32'h06000000;
    blk[17] = 32'h00000080;
    push(32'hDEADBEEF, 1'b0, 2'd0);
    push(32'h0, 1'b1, 2'd0);
    send_blk(1);
    drain("len4", 0);

    // non-final block then empty final block
    for (int i = 0; i < 18; i++) begin
      blk[i] = 32'h10203040 + i;
      push(32'h10203040 + i, 1'b0, 2'd0);
    end
    send_blk(0);
    drain("nonfinal", 0);
    clear_blk();
    blk[0] = 32'h06000000;
    blk[17] = 32'h00000080;
    push(32'h0, 1'b1, 2'd0);
    send_blk(1);
    drain("final_after", 0);

    // malformed: word 17 low byte zero
    clear_blk();
    blk[0] = 32'h06000000;
    send_blk(1);
    expect_err("w17_zero");
    small_blk("after_w17_zero");

    // malformed: in_last on word 5
    for (int i = 0; i < 6; i++) begin
      in = 32'h01000000 + i;
      in_valid = 1'b1;
      in_last = (i == 5);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    expect_err("early_last");
    small_blk("after_early_last");

    // malformed: first nonzero byte is not 0x06
    clear_blk();
    blk[0] = 32'h11223344;
    blk[17] = 32'h00000080;
    send_blk(1);
    expect_err("bad_pad");

    // malformed: no pad start anywhere
    clear_blk();
    blk[17] = 32'h00000080;
    send_blk(1);
    expect_err("no_pad");
    small_blk("after_no_pad");

    // reset during drain discards the block
    for (int i = 0; i < 18; i++) blk[i] = 32'hF0000000 + i;
    send_blk(0);
    repeat (3) @(negedge clk);
    chk("mid valid_before", out_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid rst out_valid", out_valid, 0);
    chk("mid rst in_ready", in_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("mid post in_ready", in_ready, 1);
    chk("mid post out_valid", out_valid, 0);
    small_blk("after_mid_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
